// File: rtl/bot_io_hub_pkg.sv
// Shared constants for the bot I/O hub: port map, per-bot register offsets and IRQ FSM states.
package bot_io_hub_pkg;

    localparam logic [7:0] RD_BUTTONS  = 8'h00;
    localparam logic [7:0] RD_SW_LO    = 8'h01;
    localparam logic [7:0] RD_SW_HI    = 8'h02;
    localparam logic [7:0] RD_IRQ      = 8'h03;
    localparam logic [7:0] RD_WDT      = 8'h05;

    localparam logic [7:0] WR_LED_LO   = 8'h01;
    localparam logic [7:0] WR_LED_HI   = 8'h02;
    localparam logic [7:0] WR_DP       = 8'h03;
    localparam logic [7:0] WR_MASK     = 8'h04;
    localparam logic [7:0] WR_DIG_BASE = 8'h08;

    localparam logic [7:0] BOT_BASE    = 8'h10;
    localparam int         BOT_STRIDE  = 8;

    localparam logic [2:0] OFS_LOCX    = 3'd0;
    localparam logic [2:0] OFS_LOCY    = 3'd1;
    localparam logic [2:0] OFS_INFO    = 3'd2;
    localparam logic [2:0] OFS_SENSORS = 3'd3;
    localparam logic [2:0] OFS_LMDIST  = 3'd4;
    localparam logic [2:0] OFS_RMDIST  = 3'd5;
    localparam logic [2:0] OFS_MOTCTL  = 3'd6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/bot_irq_ctrl.sv
// Pending-event latch, interrupt mask and KCPSM6 interrupt/interrupt_ack handshake FSM.
module bot_irq_ctrl
    import bot_io_hub_pkg::*;
#(
    parameter int NUM_BOTS = 2
) (
    input  logic                clk,
    input  logic                srst,
    input  logic [NUM_BOTS-1:0] upd_i,
    input  logic                mask_we_i,
    input  logic [NUM_BOTS-1:0] mask_i,
    input  logic                clr_en_i,
    input  logic [NUM_BOTS-1:0] clr_i,
    input  logic                ack_i,
    output logic [NUM_BOTS-1:0] active_o,
    output logic                irq_o
);

    logic [NUM_BOTS-1:0] pending_q, pending_d;
    logic [NUM_BOTS-1:0] mask_q, mask_d;
    irq_state_e          state_q, state_d;
    logic                irq_q, irq_d;

    // Set is applied after clear so a same-cycle event survives the read-to-clear.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d = pending_d & ~clr_i;
        end
        pending_d = pending_d | upd_i;
        mask_d    = mask_we_i ? mask_i : mask_q;
    end

    assign active_o = pending_q & mask_q;

    always_comb begin
        state_d = state_q;
        irq_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|active_o) state_d = REQ;
            end
            REQ: begin
                irq_d = ~ack_i;
                if (ack_i) state_d = SERVICE;
            end
            SERVICE: begin
                if (~|active_o) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            pending_q <= '0;
            mask_q    <= '0;
            state_q   <= IDLE;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            state_q   <= state_d;
            irq_q     <= irq_d;
        end
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/bot_io_hub.sv
// KCPSM6 port-bus hub for NUM_BOTS RojoBot channels, display, LEDs, buttons and switches.
// Optional per-bot motor watchdog enabled by defining BOT_IO_HUB_WATCHDOG_EN.
module bot_io_hub
    import bot_io_hub_pkg::*;
#(
    parameter int NUM_BOTS   = 2,
    parameter int LED_WIDTH  = 16,
    parameter int WDT_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            port_id,
    input  logic [7:0]            out_port,
    output logic [7:0]            in_port,
    input  logic                  write_strobe,
    input  logic                  k_write_strobe,
    input  logic                  read_strobe,
    output logic                  interrupt,
    input  logic                  interrupt_ack,
    input  logic [NUM_BOTS-1:0]   bot_upd,
    input  logic [8*NUM_BOTS-1:0] bot_locx,
    input  logic [8*NUM_BOTS-1:0] bot_locy,
    input  logic [8*NUM_BOTS-1:0] bot_info,
    input  logic [8*NUM_BOTS-1:0] bot_sensors,
    input  logic [8*NUM_BOTS-1:0] bot_lmdist,
    input  logic [8*NUM_BOTS-1:0] bot_rmdist,
    output logic [8*NUM_BOTS-1:0] bot_motctl,
    input  logic [3:0]            buttons,
    input  logic [15:0]           switches,
    output logic [39:0]           dig,
    output logic [7:0]            dp,
    output logic [LED_WIDTH-1:0]  led
);

    // OUTPUTK only carries a 4-bit port, so it can never reach the bot channels.
    logic       wr_en;
    logic [7:0] wr_addr;
    assign wr_en   = write_strobe | k_write_strobe;
    assign wr_addr = write_strobe ? port_id : {4'h0, port_id[3:0]};

    logic [7:0]            in_port_q, in_port_d;
    logic [LED_WIDTH-1:0]  led_q;
    logic [7:0]            dp_q;
    logic [NUM_BOTS-1:0]   irq_active;
    logic [8*NUM_BOTS-1:0] bot_rd;
    logic [7:0]            irq_byte, wdt_byte;

    bot_irq_ctrl #(.NUM_BOTS(NUM_BOTS)) u_irq (
        .clk       (clk),
        .srst      (rst),
        .upd_i     (bot_upd),
        .mask_we_i (wr_en && (wr_addr == WR_MASK)),
        .mask_i    (out_port[NUM_BOTS-1:0]),
        .clr_en_i  (read_strobe && (port_id == RD_IRQ)),
        .clr_i     (in_port_q[NUM_BOTS-1:0]),
        .ack_i     (interrupt_ack),
        .active_o  (irq_active),
        .irq_o     (interrupt)
    );

    always_comb begin
        irq_byte = 8'h00;
        irq_byte[NUM_BOTS-1:0] = irq_active;
    end

    always_comb begin
        in_port_d = 8'h00;
        case (port_id)
            RD_BUTTONS: in_port_d = {4'b0, buttons};
            RD_SW_LO:   in_port_d = switches[7:0];
            RD_SW_HI:   in_port_d = switches[15:8];
            RD_IRQ:     in_port_d = irq_byte;
            RD_WDT:     in_port_d = wdt_byte;
            default:    ;
        endcase
        for (int b = 0; b < NUM_BOTS; b++) begin
            in_port_d = in_port_d | bot_rd[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_port_q <= 8'h00;
            led_q     <= '0;
            dp_q      <= 8'h00;
        end else begin
            in_port_q <= in_port_d;
            if (wr_en && (wr_addr == WR_LED_LO)) led_q[7:0] <= out_port;
            if (wr_en && (wr_addr == WR_LED_HI)) led_q[LED_WIDTH-1:8] <= out_port[LED_WIDTH-9:0];
            if (wr_en && (wr_addr == WR_DP))     dp_q <= out_port;
        end
    end

    assign in_port = in_port_q;
    assign led     = led_q;
    assign dp      = dp_q;

    for (genvar gi = 0; gi < 8; gi++) begin : g_dig
        logic [4:0] dig_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                dig_q <= 5'h00;
            end else if (wr_en && (wr_addr == (WR_DIG_BASE | 8'(gi)))) begin
                dig_q <= out_port[4:0];
            end
        end
        assign dig[5*gi +: 5] = dig_q;
    end

`ifdef BOT_IO_HUB_WATCHDOG_EN
    logic [NUM_BOTS-1:0] wdt_flags;
    always_comb begin
        wdt_byte = 8'h00;
        wdt_byte[NUM_BOTS-1:0] = wdt_flags;
    end
`else
    assign wdt_byte = 8'h00;
`endif

    for (genvar gi = 0; gi < NUM_BOTS; gi++) begin : g_bot
        localparam logic [7:0] BASE = BOT_BASE + 8'(BOT_STRIDE * gi);
        logic       hit, mot_we, timeout;
        logic [7:0] rd_val;
        logic [7:0] motctl_q;

        assign hit    = (port_id[7:3] == BASE[7:3]);
        assign mot_we = wr_en && (wr_addr == (BASE | {5'b0, OFS_MOTCTL}));

        always_comb begin
            rd_val = 8'h00;
            if (hit) begin
                case (port_id[2:0])
                    OFS_LOCX:    rd_val = bot_locx[8*gi +: 8];
                    OFS_LOCY:    rd_val = bot_locy[8*gi +: 8];
                    OFS_INFO:    rd_val = bot_info[8*gi +: 8];
                    OFS_SENSORS: rd_val = bot_sensors[8*gi +: 8];
                    OFS_LMDIST:  rd_val = bot_lmdist[8*gi +: 8];
                    OFS_RMDIST:  rd_val = bot_rmdist[8*gi +: 8];
                    default:     ;
                endcase
            end
        end
        assign bot_rd[8*gi +: 8] = rd_val;

`ifdef BOT_IO_HUB_WATCHDOG_EN
        localparam int CW = $clog2(WDT_CYCLES + 1);
        logic [CW-1:0] cnt_q;
        logic          arm_q, wdt_q;

        // Counter only runs after a motctl write; it fires once, then idles at zero.
        assign timeout = arm_q && !mot_we && (cnt_q == '0);

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
                arm_q <= 1'b0;
                wdt_q <= 1'b0;
            end else begin
                if (mot_we) begin
                    cnt_q <= CW'(WDT_CYCLES);
                    arm_q <= 1'b1;
                end else if (arm_q) begin
                    if (cnt_q == '0) arm_q <= 1'b0;
                    else             cnt_q <= cnt_q - CW'(1);
                end
                if (read_strobe && (port_id == RD_WDT) && in_port_q[gi]) wdt_q <= 1'b0;
                if (timeout) wdt_q <= 1'b1;
            end
        end
        assign wdt_flags[gi] = wdt_q;
`else
        assign timeout = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                motctl_q <= 8'h00;
            end else if (mot_we) begin
                motctl_q <= out_port;
            end else if (timeout) begin
                motctl_q <= 8'h00;
            end
        end
        assign bot_motctl[8*gi +: 8] = motctl_q;
    end

endmodule

// File: tb/tb_bot_io_hub.sv
// Self-checking bench for bot_io_hub: vector table, handshake sequences and randomized model check.
module tb_bot_io_hub;
    localparam int NB  = 2;
    localparam int LW  = 16;
    localparam int WDT = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    port_id, out_port, in_port;
    logic          write_strobe, k_write_strobe, read_strobe;
    logic          interrupt, interrupt_ack;
    logic [NB-1:0] bot_upd;
    logic [8*NB-1:0] bot_locx, bot_locy, bot_info, bot_sensors, bot_lmdist, bot_rmdist, bot_motctl;
    logic [3:0]    buttons;
    logic [15:0]   switches;
    logic [39:0]   dig;
    logic [7:0]    dp;
    logic [LW-1:0] led;

    logic [7:0] bot_reg [6][NB];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NB; gi++) begin : g_drv
        assign bot_locx[8*gi +: 8]    = bot_reg[0][gi];
        assign bot_locy[8*gi +: 8]    = bot_reg[1][gi];
        assign bot_info[8*gi +: 8]    = bot_reg[2][gi];
        assign bot_sensors[8*gi +: 8] = bot_reg[3][gi];
        assign bot_lmdist[8*gi +: 8]  = bot_reg[4][gi];
        assign bot_rmdist[8*gi +: 8]  = bot_reg[5][gi];
    end

    bot_io_hub #(.NUM_BOTS(NB), .LED_WIDTH(LW), .WDT_CYCLES(WDT)) dut (
        .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port), .in_port(in_port),
        .write_strobe(write_strobe), .k_write_strobe(k_write_strobe), .read_strobe(read_strobe),
        .interrupt(interrupt), .interrupt_ack(interrupt_ack), .bot_upd(bot_upd),
        .bot_locx(bot_locx), .bot_locy(bot_locy), .bot_info(bot_info), .bot_sensors(bot_sensors),
        .bot_lmdist(bot_lmdist), .bot_rmdist(bot_rmdist), .bot_motctl(bot_motctl),
        .buttons(buttons), .switches(switches), .dig(dig), .dp(dp), .led(led)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the software-visible state
    logic [15:0]   m_led;
    logic [7:0]    m_dp;
    logic [4:0]    m_dig [8];
    logic [7:0]    m_mot [NB];
    logic [NB-1:0] m_mask, m_pend;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        int ch, ofs;
        if (a == 8'h00) return {4'h0, buttons};
        if (a == 8'h01) return switches[7:0];
        if (a == 8'h02) return switches[15:8];
        if (a == 8'h03) return 8'(m_pend & m_mask);
        if (a >= 8'h10) begin
            ch  = (int'(a) - 16) / 8;
            ofs = (int'(a) - 16) % 8;
            if (ch < NB && ofs < 6) return bot_reg[ofs][ch];
        end
        return 8'h00;
    endfunction

    task automatic do_write(input logic k, input logic [7:0] a, input logic [7:0] d);
        logic [7:0] ea;
        int ch, ofs;
        @(negedge clk);
        port_id = a; out_port = d; write_strobe = !k; k_write_strobe = k;
        @(negedge clk);
        write_strobe = 1'b0; k_write_strobe = 1'b0;
        ea = k ? {4'h0, a[3:0]} : a;
        ch  = (int'(ea) - 16) / 8;
        ofs = (int'(ea) - 16) % 8;
        if (ea == 8'h01)                    m_led[7:0]  = d;
        else if (ea == 8'h02)               m_led[15:8] = d;
        else if (ea == 8'h03)               m_dp        = d;
        else if (ea == 8'h04)               m_mask      = d[NB-1:0];
        else if (ea >= 8'h08 && ea < 8'h10) m_dig[ea-8] = d[4:0];
        else if (ea >= 8'h10 && ofs == 6 && ch < NB) m_mot[ch] = d;
    endtask

    // KCPSM6-style INPUT: port_id for two cycles, read_strobe in the second.
    task automatic do_read(input logic [7:0] a, input logic [NB-1:0] upd,
                           output logic [7:0] d, output logic [7:0] e);
        e = model_rd(a);
        @(negedge clk);
        port_id = a;
        @(negedge clk);
        read_strobe = 1'b1; bot_upd = upd; d = in_port;
        @(negedge clk);
        read_strobe = 1'b0; bot_upd = '0;
        if (a == 8'h03) m_pend = m_pend & ~e[NB-1:0];
        m_pend = m_pend | upd;
    endtask

    task automatic pulse_upd(input logic [NB-1:0] u);
        @(negedge clk); bot_upd = u;
        @(negedge clk); bot_upd = '0;
        m_pend = m_pend | u;
    endtask

    task automatic do_ack();
        @(negedge clk); interrupt_ack = 1'b1;
        @(negedge clk); interrupt_ack = 1'b0;
    endtask

    task automatic wait_irq(input string name);
        for (int i = 0; i < 20; i++) begin
            if (interrupt === 1'b1) break;
            @(negedge clk);
        end
        check(name, interrupt, 1'b1);
        $display("txn %s interrupt=%b", name, interrupt);
    endtask

    task automatic read_chk(input string name, input logic [7:0] a, input logic [NB-1:0] upd,
                            input logic [7:0] exp);
        logic [7:0] d, e;
        do_read(a, upd, d, e);
        check(name, d, exp);
        $display("txn %s read %02h -> %02h", name, a, d);
    endtask

    function automatic logic [7:0] obs(input int sel);
        if (sel == 1) return led[7:0];
        if (sel == 2) return led[15:8];
        if (sel == 3) return dp;
        if (sel >= 4 && sel < 12) return {3'b0, dig[5*(sel-4) +: 5]};
        if (sel >= 12) return bot_motctl[8*(sel-12) +: 8];
        return 8'h00;
    endfunction

    // sel: 0 = value read back, 1/2 = led lo/hi, 3 = dp, 4+d = digit d, 12+b = motctl of bot b
    typedef struct {
        logic       rd;
        logic       k;
        logic [7:0] addr;
        logic [7:0] data;
        int         sel;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rd, input logic k, input logic [7:0] a,
                                input logic [7:0] d, input int sel, input logic [7:0] exp);
        vec_t v;
        v.rd = rd; v.k = k; v.addr = a; v.data = d; v.sel = sel; v.exp = exp;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  d, e;
        logic [39:0] expd;
        logic [7:0]  a;

        rst = 1'b1; port_id = '0; out_port = '0; write_strobe = 0; k_write_strobe = 0;
        read_strobe = 0; interrupt_ack = 0; bot_upd = '0;
        buttons = 4'hA; switches = 16'hBEEF;
        for (int b = 0; b < NB; b++)
            for (int o = 0; o < 6; o++) bot_reg[o][b] = 8'(8'h30 + 8*b + o);
        bot_reg[1][1] = 8'h42;
        m_led = '0; m_dp = '0; m_mask = '0; m_pend = '0;
        for (int i = 0; i < 8; i++) m_dig[i] = '0;
        for (int b = 0; b < NB; b++) m_mot[b] = '0;

        repeat (2) @(negedge clk);
        check("rst_in_port", in_port, 8'h00);
        check("rst_interrupt", interrupt, 1'b0);
        check("rst_motctl", bot_motctl, 16'h0000);
        check("rst_dp", dp, 8'h00);
        check("rst_led", led, 16'h0000);
        check("rst_dig", dig, 40'h0);
        rst = 1'b0;
        read_chk("rst_pending", 8'h03, '0, 8'h00);

        vecs.push_back(mk(0, 0, 8'h09, 8'h1F, 5,  8'h1F));
        vecs.push_back(mk(0, 1, 8'h01, 8'hA5, 1,  8'hA5));
        vecs.push_back(mk(0, 0, 8'h1E, 8'h33, 13, 8'h33));
        vecs.push_back(mk(0, 1, 8'h16, 8'h44, 13, 8'h33));
        vecs.push_back(mk(0, 0, 8'h02, 8'h5A, 2,  8'h5A));
        vecs.push_back(mk(0, 1, 8'h03, 8'h81, 3,  8'h81));
        vecs.push_back(mk(0, 1, 8'h1E, 8'h77, 10, 8'h17));
        vecs.push_back(mk(0, 0, 8'h0F, 8'hE3, 11, 8'h03));
        vecs.push_back(mk(0, 0, 8'h40, 8'hFF, 1,  8'hA5));
        vecs.push_back(mk(0, 0, 8'h16, 8'h5C, 12, 8'h5C));
        vecs.push_back(mk(1, 0, 8'h19, 8'h00, 0,  8'h42));
        vecs.push_back(mk(1, 0, 8'h21, 8'h00, 0,  8'h00));
        vecs.push_back(mk(1, 0, 8'h00, 8'h00, 0,  8'h0A));
        vecs.push_back(mk(1, 0, 8'h01, 8'h00, 0,  8'hEF));
        vecs.push_back(mk(1, 0, 8'h02, 8'h00, 0,  8'hBE));
        vecs.push_back(mk(1, 0, 8'h10, 8'h00, 0,  8'h30));
        vecs.push_back(mk(1, 0, 8'h15, 8'h00, 0,  8'h35));
        vecs.push_back(mk(1, 0, 8'h1D, 8'h00, 0,  8'h3D));
        vecs.push_back(mk(1, 0, 8'h16, 8'h00, 0,  8'h00));
        vecs.push_back(mk(1, 0, 8'h1F, 8'h00, 0,  8'h00));
        vecs.push_back(mk(1, 0, 8'h03, 8'h00, 0,  8'h00));
`ifndef BOT_IO_HUB_WATCHDOG_EN
        vecs.push_back(mk(1, 0, 8'h05, 8'h00, 0,  8'h00));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rd) begin
                do_read(vecs[i].addr, '0, d, e);
            end else begin
                do_write(vecs[i].k, vecs[i].addr, vecs[i].data);
                d = obs(vecs[i].sel);
            end
            check($sformatf("vec%0d", i), d, vecs[i].exp);
            $display("txn vec%0d rd=%b k=%b addr=%02h data=%02h obs=%02h", i,
                     vecs[i].rd, vecs[i].k, vecs[i].addr, vecs[i].data, d);
        end

        // Basic handshake
        do_write(0, 8'h04, 8'h03);
        pulse_upd(2'b01);
        wait_irq("irq_raise");
        repeat (2) @(negedge clk);
        check("irq_hold_until_ack", interrupt, 1'b1);
        do_ack();
        check("irq_drop_after_ack", interrupt, 1'b0);
        read_chk("irq_read", 8'h03, '0, 8'h01);
        read_chk("irq_cleared", 8'h03, '0, 8'h00);
        repeat (4) @(negedge clk);
        check("irq_idle_quiet", interrupt, 1'b0);

        // New event arrives in the same cycle as the clearing read during SERVICE
        pulse_upd(2'b01);
        wait_irq("svc_irq1");
        do_ack();
        read_chk("svc_read_bit0", 8'h03, 2'b10, 8'h01);
        repeat (4) @(negedge clk);
        check("svc_no_irq_while_pending", interrupt, 1'b0);
        read_chk("svc_event_kept", 8'h03, '0, 8'h02);
        repeat (4) @(negedge clk);
        check("svc_back_idle_quiet", interrupt, 1'b0);
        pulse_upd(2'b10);
        wait_irq("svc_second_irq");
        do_ack();
        read_chk("svc_second_read", 8'h03, '0, 8'h02);

        // Masking during REQ must not withdraw the request
        pulse_upd(2'b01);
        wait_irq("mask_irq");
        do_write(0, 8'h04, 8'h00);
        repeat (3) @(negedge clk);
        check("req_hold_masked", interrupt, 1'b1);
        do_ack();
        check("req_masked_ack_drop", interrupt, 1'b0);
        repeat (3) @(negedge clk);
        read_chk("masked_read_zero", 8'h03, '0, 8'h00);
        check("masked_no_irq", interrupt, 1'b0);
        do_write(0, 8'h04, 8'h03);
        wait_irq("unmask_irq");
        do_ack();
        read_chk("unmask_read", 8'h03, '0, 8'h01);

`ifdef BOT_IO_HUB_WATCHDOG_EN
        do_read(8'h05, '0, d, e);
        do_write(0, 8'h16, 8'h33);
        repeat (10) @(negedge clk);
        check("wdt_before_timeout", bot_motctl[7:0], 8'h33);
        @(negedge clk);
        check("wdt_stop", bot_motctl[7:0], 8'h00);
        m_mot[0] = 8'h00;
        read_chk("wdt_status", 8'h05, '0, 8'h01);
        read_chk("wdt_status_cleared", 8'h05, '0, 8'h00);
`endif

        // Randomized traffic against the model
        for (int b = 0; b < NB; b++)
            for (int o = 0; o < 6; o++) bot_reg[o][b] = 8'($urandom_range(0, 255));
        buttons  = 4'($urandom_range(0, 15));
        switches = 16'($urandom_range(0, 65535));
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    a = 8'($urandom_range(0, 47));
                    d = 8'($urandom_range(0, 255));
                    do_write(1'($urandom_range(0, 1)), a, d);
                    check("rand_led", led, m_led);
                    check("rand_dp", dp, m_dp);
                    for (int j = 0; j < 8; j++) expd[5*j +: 5] = m_dig[j];
                    check("rand_dig", dig, expd);
`ifndef BOT_IO_HUB_WATCHDOG_EN
                    check("rand_motctl", bot_motctl, {m_mot[1], m_mot[0]});
`endif
                    $display("txn rand%0d write %02h <= %02h", i, a, d);
                end
                1: begin
                    a = 8'($urandom_range(0, 47));
`ifdef BOT_IO_HUB_WATCHDOG_EN
                    if (a == 8'h05) a = 8'h06;
`endif
                    do_read(a, '0, d, e);
                    check($sformatf("rand_read_%02h", a), d, e);
                    $display("txn rand%0d read %02h -> %02h (model %02h)", i, a, d, e);
                end
                default: begin
                    pulse_upd(NB'($urandom_range(1, 3)));
                    $display("txn rand%0d bot_upd pulse", i);
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bot_io_hub.md
Name: bot_io_hub

Overview:
- Parametrised successor to the single-bot PicoBlaze I/O interface.
- Connects one KCPSM6 port bus to NUM_BOTS RojoBot register sets, plus the 7-seg digits, decimal points, LEDs, debounced buttons and debounced switches.
- Per-bot update pulses are latched into a maskable pending-interrupt register, driven by a request/acknowledge FSM compatible with the KCPSM6 interrupt/interrupt_ack protocol.
- Sits between the CPU, the bot instances and the display/debounce blocks in the top level.

Parameters:
- NUM_BOTS, 2, number of RojoBot channels; legal range 1..4.
- LED_WIDTH, 16, width of the LED output; legal range 9..16.
- WDT_CYCLES, 50_000_000, watchdog timeout in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous active-high reset.
- port_id  in  8  KCPSM6 port address.
- out_port  in  8  KCPSM6 write data.
- in_port  out  8  registered read data to KCPSM6.
- write_strobe  in  1  OUTPUT strobe.
- k_write_strobe  in  1  OUTPUTK strobe.
- read_strobe  in  1  INPUT strobe.
- interrupt  out  1  interrupt request.
- interrupt_ack  in  1  KCPSM6 acknowledge.
- bot_upd  in  NUM_BOTS  per-bot register-update pulse, one cycle wide.
- bot_locx, bot_locy, bot_info, bot_sensors, bot_lmdist, bot_rmdist  in  8*NUM_BOTS  each; bot b occupies bits [8b+7:8b].
- bot_motctl  out  8*NUM_BOTS  motor control per bot.
- buttons  in  4  debounced {left,up,right,down}.
- switches  in  16  debounced switches.
- dig  out  40  eight 5-bit digit codes; digit d occupies bits [5d+4:5d].
- dp  out  8  decimal points; bits [7:4] high group, [3:0] low group.
- led  out  LED_WIDTH  LEDs.

Behaviour:
- Reset (synchronous, rst=1): in_port, interrupt, bot_motctl, dp, led, irq_mask and pending all 0; dig = 5'h00 for every digit; FSM goes to IDLE.
- Read map:
  - 0x00: {4'b0, buttons}.
  - 0x01: switches[7:0]; 0x02: switches[15:8].
  - 0x03: pending & irq_mask, read-to-clear.
  - 0x10+8b+{0..5}: LocX, LocY, BotInfo, Sensors, LMDist, RMDist of bot b.
  - All other addresses, including channels b >= NUM_BOTS, return 0x00.
- in_port is registered every cycle from the current port_id, so it is valid 1 cycle after port_id. This meets the KCPSM6 2-cycle input timing.
- Write map:
  - 0x01: led[7:0].
  - 0x02: led[LED_WIDTH-1:8]; extra data bits are dropped.
  - 0x03: dp. 0x04: irq_mask[NUM_BOTS-1:0].
  - 0x08..0x0F: digit 0..7 = out_port[4:0].
  - 0x10+8b+6: bot_motctl of bot b.
  - Writes to unmapped addresses are ignored.
- Write timing: a write takes effect on the clk edge where the strobe is sampled high; the output changes the next cycle.
- k_write_strobe decodes {4'h0, port_id[3:0]} only, so bot channels cannot be written via OUTPUTK.
- Pending bits: pending[b] is set when bot_upd[b]=1. On read_strobe at 0x03, bits set in the in_port value held that cycle are cleared. If a set and a clear of the same bit occur in the same cycle, the set wins.
- IRQ FSM:
  - IDLE: when (pending & irq_mask) != 0, go to REQ.
  - REQ: interrupt=1; on interrupt_ack go to SERVICE.
  - SERVICE: interrupt=0; when (pending & irq_mask) == 0, go to IDLE.
  - interrupt is a registered output: it rises 1 cycle after entering REQ and falls on the cycle after ack.
  - A new event during SERVICE is not lost. It keeps pending non-zero, so the FSM stays in SERVICE until software clears it; the next request is raised after returning to IDLE.
  - Masking all bits while in REQ does not withdraw the request; it waits for ack.
- Reset during any state forces IDLE, clears pending and drops interrupt on the next edge.

Optional Feature:
- Macro: BOT_IO_HUB_WATCHDOG_EN.
- Enabled:
  - One counter per bot, reloaded to WDT_CYCLES on every write to that bot's motctl.
  - On reaching 0, that bot's bot_motctl is forced to 0x00 (stop) and sticky status bit wdt[b] is set.
  - The status is readable at 0x05 as {(8-NUM_BOTS)'b0, wdt}, read-to-clear.
  - The counter holds at 0 until the next motctl write.
- Disabled: no counters; 0x05 reads 0x00; WDT_CYCLES is unused.

Decomposition:
- Package bot_io_hub_pkg: read/write port address constants, BOT_BASE=0x10, BOT_STRIDE=8, the register offset constants, and the IRQ state encoding IDLE/REQ/SERVICE.
- Sub-module bot_irq_ctrl: owns the pending register, the mask and the FSM.
- Port decode and register files stay in the parent.

Test Plan:
- Reset check: assert rst for 2 cycles -> all outputs 0; after reset, reading port 0x03 gives 0x00.
- Write ports: OUTPUT 0x1F to 0x09 -> dig[9:5]=5'h1F; OUTPUTK 0xA5 to 0x01 -> led[7:0]=0xA5; OUTPUT 0x33 to 0x1E -> bot_motctl[15:8]=0x33.
- Read ports: NUM_BOTS=2, bot1 locy=0x42 -> read 0x19 returns 0x42 one cycle later; read 0x21 (bot 2, absent) returns 0x00.
- Interrupt handshake: mask=0x03; pulse bot_upd[0] -> interrupt=1; ack -> interrupt=0; read 0x03 -> returns 0x01, pending clears, FSM returns to IDLE.
- Event during SERVICE: pulse bot_upd[1] during SERVICE, in the same cycle as the 0x03 read of 0x01 -> bit1 stays pending, then a second interrupt is raised.
- Watchdog: with BOT_IO_HUB_WATCHDOG_EN and WDT_CYCLES=10, write motctl 0x33 to bot0 and wait 11 cycles -> bot_motctl[7:0]=0x00; read 0x05 returns 0x01.
